// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and launch controller placed directly in front of uart_tx.
// A producer pushes bytes with a single-cycle write strobe. The bytes are
// stored in a circular FIFO. A small controller drains the FIFO one frame at
// a time: it pulses o_TX_DV together with o_TX_Byte, and it follows the
// transmitter's o_TX_Active / o_TX_Done handshake. Frames therefore go out
// back-to-back without the producer having to wait for the line.
//
// Parameters
//   DEPTH   number of byte entries (power of two, >= 2)
//   ADDR_W  pointer width, log2(DEPTH)
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, one byte per high cycle
//   i_Wr_Byte    byte to enqueue, sampled with i_Wr_DV
//   o_Full       count == DEPTH (registered)
//   o_Empty      count == 0 (registered)
//   o_Count      number of stored bytes, 0..DEPTH (registered)
//   o_Overflow   sticky; set by a write while full, cleared by reset
//   o_TX_DV      single-cycle launch pulse to uart_tx i_TX_DV
//   o_TX_Byte    byte to uart_tx i_TX_Byte, held from one pop to the next
//   i_TX_Active  from uart_tx o_TX_Active
//   i_TX_Done    from uart_tx o_TX_Done
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done
);

    typedef enum logic [2:0] {
        ST_SYNC        = 3'd0,
        ST_IDLE        = 3'd1,
        ST_LAUNCH      = 3'd2,
        ST_WAIT_ACTIVE = 3'd3,
        ST_WAIT_DONE   = 3'd4,
        ST_GAP         = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_COUNT = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W-1:0] ZERO_PTR   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1'b1);

    // Storage. The array has no reset: after a reset the pointers and the
    // count make any old contents unreachable.
    logic [7:0]        mem_q [DEPTH];

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              full_q,     full_d;
    logic              empty_q,    empty_d;
    logic              overflow_q, overflow_d;
    logic              tx_dv_q,    tx_dv_d;
    logic [7:0]        tx_byte_q,  tx_byte_d;

    logic              wr_accept_s;
    logic              wr_reject_s;
    logic              pop_s;

    // Write qualification. Fullness comes from the registered flag only. A
    // write while full is refused even if a pop happens in the same cycle.
    always_comb begin
        wr_accept_s = i_Wr_DV & ~full_q;
        wr_reject_s = i_Wr_DV &  full_q;
    end

    // Controller next state. A pop happens only on the IDLE->LAUNCH
    // transition. The launch pulse and the byte are staged here so that both
    // come out of flops during LAUNCH.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        rd_ptr_d  = rd_ptr_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // Let a frame still running in the unreset uart_tx finish
                // before anything new is launched.
                if (!i_TX_Active) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_IDLE: begin
                if (!empty_q) begin
                    pop_s     = 1'b1;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + ONE_PTR;
                    state_d   = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                if (i_TX_Active) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACTIVE;
                end
            end
            ST_WAIT_DONE: begin
                // Active falling low also ends the frame, so a missed Done
                // pulse cannot stall the controller.
                if (i_TX_Done || !i_TX_Active) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                // One cycle that covers the transmitter's cleanup state.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Pointer, count and flag next values. Writes and pops are guarded by
    // the full and empty flags, so the count stays inside 0..DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase
        full_d     = (count_d == FULL_COUNT);
        empty_d    = (count_d == ZERO_COUNT);
        overflow_d = overflow_q | wr_reject_s;
    end

    // Byte storage: write the accepted byte at the write pointer.
    always_ff @(posedge i_Clock) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    // State, pointers, count, flags and transmitter outputs, with
    // synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= ST_SYNC;
            wr_ptr_q   <= ZERO_PTR;
            rd_ptr_q   <= ZERO_PTR;
            count_q    <= ZERO_COUNT;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Every output comes straight from a flop.
    always_comb begin
        o_Full     = full_q;
        o_Empty    = empty_q;
        o_Count    = count_q;
        o_Overflow = overflow_q;
        o_TX_DV    = tx_dv_q;
        o_TX_Byte  = tx_byte_q;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller that sits directly upstream of `uart_tx`. It accepts bytes from a producer through a single-cycle write strobe and stores them in a circular FIFO. It drains the FIFO into `uart_tx` one frame at a time by pulsing `i_TX_DV`/`i_TX_Byte` and tracking `o_TX_Active`/`o_TX_Done`. Frames go out back-to-back without the producer having to wait for the line.

## Interface

Parameters:
- `DEPTH`, default 16: number of byte entries. Must be a power of two, at least 2.
- `ADDR_W`, default 4: pointer width. Must equal log2(DEPTH).

Ports:
- `i_Clock` in 1: system clock; all logic is on the rising edge.
- `i_Reset` in 1: reset, synchronous, active-high.
- `i_Wr_DV` in 1: write strobe. One byte is offered per cycle in which it is high.
- `i_Wr_Byte` in 8: byte to enqueue. Sampled when `i_Wr_DV` is high.
- `o_Full` out 1: high when count == DEPTH.
- `o_Empty` out 1: high when count == 0.
- `o_Count` out ADDR_W+1: number of stored bytes, range 0..DEPTH.
- `o_Overflow` out 1: sticky flag. Set by a write while full; cleared only by reset.
- `o_TX_DV` out 1: connects to `uart_tx` `i_TX_DV`. Single-cycle launch pulse.
- `o_TX_Byte` out 8: connects to `uart_tx` `i_TX_Byte`.
- `i_TX_Active` in 1: connects to `uart_tx` `o_TX_Active`.
- `i_TX_Done` in 1: connects to `uart_tx` `o_TX_Done`.

## Operation

**Storage**
- DEPTH×8 register array.
- Write pointer and read pointer, each ADDR_W bits, wrapping modulo DEPTH.
- Separate `o_Count` register.

**Write path**
- If `i_Wr_DV` is high and `o_Full` is low: store the byte at the write pointer, then increment the write pointer.
- If `i_Wr_DV` is high and `o_Full` is high: discard the byte, set `o_Overflow`, leave pointers and count unchanged.
- Fullness is judged from the registered count only. A write while full is rejected even if a pop happens in the same cycle.

**Pop**
- Occurs only in the cycle the FSM leaves IDLE.
- Action: `o_TX_Byte` <= mem[read pointer], then increment the read pointer.

**Count update per cycle**
- Accepted write and pop together: count unchanged.
- Accepted write only: count + 1.
- Pop only: count − 1.
- Count never leaves 0..DEPTH.

**FSM states**
- **SYNC**
  - Entered on reset.
  - Stays while `i_TX_Active` is high, so a frame already in flight in the unreset `uart_tx` completes.
  - Goes to IDLE on the first cycle `i_TX_Active` is low.
- **IDLE**
  - If not empty: pop, drive `o_TX_DV` = 1 for the next cycle, go to LAUNCH.
  - Otherwise stay.
- **LAUNCH**
  - `o_TX_DV` is 1 for exactly this cycle.
  - Unconditionally goes to WAIT_ACTIVE.
- **WAIT_ACTIVE**
  - Goes to WAIT_DONE when `i_TX_Active` is high.
  - No timeout.
- **WAIT_DONE**
  - Goes to GAP when `i_TX_Done` is high, or when `i_TX_Active` has returned low.
- **GAP**
  - One cycle that covers `uart_tx` cleanup.
  - Then goes to IDLE.

**Output holding rule**
- `o_TX_Byte` holds its value from the pop until the next pop. It is never changed mid-frame.

## Timing

**Reset values**
- `o_TX_DV` = 0, `o_TX_Byte` = 8'h00.
- `o_Count` = 0, `o_Empty` = 1, `o_Full` = 0, `o_Overflow` = 0.
- Pointers = 0. FSM = SYNC.

**Reset mid-operation**
- FIFO contents are logically discarded and any pending launch is cancelled.
- If `uart_tx` is mid-frame, that frame finishes on the line and no new launch occurs until `i_TX_Active` is low.

**Latency**
- Write on edge N into an empty FIFO with the FSM in IDLE: `o_Empty` falls after edge N.
- `o_TX_DV` is high from edge N+1 to edge N+2.

**Throughput**
- The next `o_TX_DV` comes at least 2 cycles after `i_TX_Done` is first seen: WAIT_DONE→GAP→IDLE→LAUNCH.
- Inter-frame idle on the line is therefore a few clocks, well under one bit period.

**Flags**
- All flags are registered and are valid in the cycle after the causing edge.

**Combined boundary cases**
- Simultaneous write and pop with count = 1: count stays 1, and the popped byte is the old head.
- Wrap-around: after DEPTH accepted writes and DEPTH pops, both pointers return to 0 and order is preserved.

## Test plan

Bench setup for all scenarios: `uart_tx_fifo` → `uart_tx` → `uart_rx` loopback, `CLKS_PER_BIT` = 217, 40 ns clock.

1. **Single byte.** Reset for 2 cycles, then write 8'h3F once.
   - `o_TX_DV` is high for exactly 1 cycle, 2 edges after the write.
   - `uart_rx` delivers 8'h3F.
   - `o_Count` returns to 0.
2. **Burst in order.** Write 10 bytes on consecutive cycles: 3F A0 C1 55 00 FF 1C E3 42 7A.
   - Peak `o_Count` = 9 or 10.
   - `uart_rx` delivers all 10 bytes in order.
   - `o_Overflow` stays 0.
   - Exactly 10 `o_TX_DV` pulses.
3. **Full and overflow.** Write 18 bytes on consecutive cycles, values 8'h00–8'h11, with `DEPTH` = 16.
   - `o_Full` rises.
   - `o_Overflow` is set by the rejected writes and stays 1.
   - The received sequence is the first accepted bytes in order.
   - Total received = 18 − rejected writes.
4. **Simultaneous write and pop.** Hold count at 1 and time a write into the IDLE pop cycle.
   - `o_Count` stays 1.
   - Both bytes are transmitted, old head first.
5. **Reset mid-frame.** Queue 5 bytes and assert `i_Reset` during frame 2's data bits.
   - The in-flight frame completes.
   - No `o_TX_DV` pulse while `i_TX_Active` is high.
   - `o_Empty` = 1 and `o_Count` = 0.
   - The remaining 3 bytes are never sent.
6. **Pointer wrap.** Perform 40 write/drain cycles of 1 byte each, values 8'h80 + i.
   - All 40 bytes are received correctly across pointer wrap.
   - Pointers end at 40 mod 16 = 8.
